// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Sequences an external AES key generator, buffers the 11 round
//            keys and streams them to the round datapath over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
    parameter int unsigned KR_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         encode,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         kg_cipherready,
    output logic         kg_encode,
    output logic [127:0] kg_key,
    input  logic         kg_keyready,
    input  logic [127:0] kg_rkey,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_key,
    output logic [3:0]   rk_index,
    output logic         rk_last
);

    localparam int unsigned     TW        = $clog2(KR_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LIMIT = TW'(KR_TIMEOUT - 1);
    localparam logic [3:0]      LAST_SLOT = 4'd10;
    localparam int unsigned     NUM_SLOTS = 11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COLLECT = 2'd2,
        S_ISSUE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      idx_q, idx_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            kg_encode_q, kg_encode_d;
    logic [127:0]    kg_key_q, kg_key_d;
    logic [127:0]    slots_q [0:NUM_SLOTS-1];

    logic            slot_we;
    logic [3:0]      slot_waddr;
    logic [127:0]    slot_wdata;

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign kg_encode      = kg_encode_q;
    assign kg_key         = kg_key_q;
    assign rk_valid       = (state_q == S_ISSUE);
    assign rk_index       = idx_q;
    assign rk_key         = rk_valid ? slots_q[idx_q] : '0;
    // Final key is slot 10 going forward, slot 0 going backward.
    assign rk_last        = rk_valid &&
                            (kg_encode_q ? (idx_q == LAST_SLOT) : (idx_q == 4'd0));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        idx_d          = idx_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        kg_encode_d    = kg_encode_q;
        kg_key_d       = kg_key_q;
        slot_we        = 1'b0;
        slot_waddr     = cnt_q;
        slot_wdata     = kg_rkey;
        kg_cipherready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kg_key_d    = key;
                    kg_encode_d = encode;
                    slot_we     = 1'b1;
                    slot_waddr  = 4'd0;
                    slot_wdata  = key;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                kg_cipherready = 1'b1;
                cnt_d          = 4'd1;
                tmo_d          = '0;
                state_d        = S_COLLECT;
            end
            S_COLLECT: begin
                if (kg_keyready) begin
                    slot_we = 1'b1;
                    tmo_d   = '0;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_SLOT) begin
                        state_d = S_ISSUE;
                        idx_d   = kg_encode_q ? 4'd0 : LAST_SLOT;
                    end
                end else if (tmo_q == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_ISSUE: begin
                if (rk_ready) begin
                    if (rk_last) begin
                        done_d  = 1'b1;
                        idx_d   = 4'd0;
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = kg_encode_q ? (idx_q + 4'd1) : (idx_q - 4'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            tmo_q       <= '0;
            idx_q       <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            kg_encode_q <= 1'b0;
            kg_key_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            kg_encode_q <= kg_encode_d;
            kg_key_q    <= kg_key_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else if (slot_we) begin
            slots_q[slot_waddr] <= slot_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: behavioural AES key expansion drives a
// key-generator model; each scenario task checks the streamed round keys.
`default_nettype none

module tb_aes_round_ctrl;

    localparam int unsigned TB_KR = 16;

    logic         clk, rst_n, start, encode;
    logic [127:0] key;
    logic         busy, done, err, kg_cipherready, kg_encode;
    logic [127:0] kg_key;
    logic         kg_keyready;
    logic [127:0] kg_rkey;
    logic         rk_valid, rk_ready, rk_last;
    logic [127:0] rk_key;
    logic [3:0]   rk_index;

    int errors = 0;
    int checks = 0;

    logic [127:0] rk_model [0:10];
    int           kg_limit   = 10;
    bit           kg_gaps    = 1'b1;
    bit           kg_spurious = 1'b0;
    int           kg_sent    = 0;
    time          kg_p3_time = 0;

    aes_round_ctrl #(.KR_TIMEOUT(TB_KR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .encode         (encode),
        .key            (key),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .kg_cipherready (kg_cipherready),
        .kg_encode      (kg_encode),
        .kg_key         (kg_key),
        .kg_keyready    (kg_keyready),
        .kg_rkey        (kg_rkey),
        .rk_valid       (rk_valid),
        .rk_ready       (rk_ready),
        .rk_key         (rk_key),
        .rk_index       (rk_index),
        .rk_last        (rk_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Key-generator model: after a load pulse, emits round keys 1..kg_limit.
    initial begin : kg_model
        bit active;
        int skips;
        active = 1'b0; skips = 0;
        kg_keyready = 1'b0;
        kg_rkey     = '0;
        forever begin
            @(negedge clk);
            kg_keyready = 1'b0;
            if (!rst_n) begin
                active = 1'b0;
            end else if (kg_cipherready) begin
                active = 1'b1; kg_sent = 0; skips = 0;
            end else if (active && kg_sent < kg_limit && kg_sent < 10) begin
                if (kg_gaps && skips < 3 && $urandom_range(3) == 0) begin
                    skips++;
                end else begin
                    skips = 0;
                    kg_keyready = 1'b1;
                    kg_rkey     = rk_model[kg_sent + 1];
                    kg_sent++;
                    if (kg_sent == 3) kg_p3_time = $time;
                end
            end else begin
                if (kg_sent >= 10) active = 1'b0;
                if (kg_spurious) begin
                    kg_keyready = 1'($urandom_range(1));
                    kg_rkey     = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    task automatic run_sched(input logic enc, input logic [127:0] k, input int unsigned stall_pct,
                             input bit hold_start, input bit spur, input bit fips, input int abort_after);
        int pos, slot;
        bit exp_done, fin;
        expand_key(k);
        kg_limit = 10;
        @(negedge clk);
        start = 1'b1; encode = enc; key = k;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        encode = ~enc;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        pos = 0; exp_done = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (exp_done) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b busy=%b rk_valid=%b want 1/0/0", done, busy, rk_valid);
                end
                fin = 1'b1;
            end else begin
                checks++;
                if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1 || kg_key !== k || kg_encode !== enc) begin
                    errors++;
                    $display("FAIL run_status: done=%b err=%b busy=%b kg_enc=%b kg_key=%h want 0/0/1/%b key %h",
                             done, err, busy, kg_encode, kg_key, enc, k);
                end
                if (rk_valid) begin
                    if (spur) kg_spurious = 1'b1;
                    slot = enc ? pos : 10 - pos;
                    checks++;
                    if (rk_key !== rk_model[slot] || rk_index !== 4'(slot) || rk_last !== (pos == 10)) begin
                        errors++;
                        $display("FAIL rk_out: key=%h idx=%0d last=%b want %h idx=%0d last=%b",
                                 rk_key, rk_index, rk_last, rk_model[slot], slot, pos == 10);
                    end
                    if (fips && slot == 1) begin
                        checks++;
                        if (rk_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
                            errors++; $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", rk_key);
                        end
                    end
                    if (fips && slot == 10) begin
                        checks++;
                        if (rk_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
                            errors++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_key);
                        end
                    end
                    if (pos == 10 && hold_start) start = 1'b0;
                    rk_ready = ($urandom_range(99) >= stall_pct);
                    if (rk_ready) begin
                        pos++;
                        if (pos == 11) exp_done = 1'b1;
                        if (abort_after >= 0 && pos == abort_after + 1) fin = 1'b1;
                    end
                end else begin
                    if (pos > 0) begin
                        checks++; errors++;
                        $display("FAIL valid_drop: rk_valid=0 after %0d transfers, want 1", pos);
                    end
                    rk_ready = 1'($urandom_range(1));
                end
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL run_budget: only %0d transfers seen, want 11", pos);
        end
        if (abort_after < 0) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL done_width: done=%b busy=%b err=%b want 0/0/0", done, busy, err);
            end
        end
        kg_spurious = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; encode = 1'b0; key = '0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0 || err !== 0 || kg_cipherready !== 0 || rk_valid !== 0 ||
            rk_last !== 0 || rk_index !== 4'd0 || kg_key !== '0 || kg_encode !== 0 || rk_key !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b cr=%b v=%b last=%b idx=%0d kg_key=%h kg_enc=%b rk_key=%h want all 0",
                     busy, done, err, kg_cipherready, rk_valid, rk_last, rk_index, kg_key, kg_encode, rk_key);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encrypt();
        run_sched(1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 1'b0, 1'b1, -1);
    endtask

    task automatic test_decrypt();
        run_sched(1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 1'b0, 1'b1, -1);
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 3; r++)
            run_sched(1'($urandom_range(1)), {$urandom, $urandom, $urandom, $urandom}, 50, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_timeout();
        bit seen;
        expand_key({$urandom, $urandom, $urandom, $urandom});
        kg_limit = 3;
        @(negedge clk);
        start = 1'b1; encode = 1'b1; key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            checks++;
            if (rk_valid !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL timeout_quiet: rk_valid=%b done=%b want 0/0", rk_valid, done);
            end
            if (err === 1'b1) begin
                seen = 1'b1;
                checks++;
                if ($time != kg_p3_time + TB_KR * 10 + 10) begin
                    errors++; $display("FAIL err_time: at %0t want %0t", $time, kg_p3_time + TB_KR * 10 + 10);
                end
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: busy=%b want 0", busy); end
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL err_missing: err=%b want a pulse", err);
        end else if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL err_width: err=%b busy=%b done=%b want 0/0/0", err, busy, done);
        end
        kg_limit = 10;
    endtask

    task automatic test_reset_mid_issue();
        run_sched(1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_index !== 4'd0 || kg_key !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_issue_reset: v=%b busy=%b idx=%0d kg_key=%h done=%b want 0/0/0/0/0",
                     rk_valid, busy, rk_index, kg_key, done);
        end
        rst_n = 1'b1;
        run_sched(1'b1, {$urandom, $urandom, $urandom, $urandom}, 20, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_start_held_spurious();
        run_sched(1'b1, {$urandom, $urandom, $urandom, $urandom}, 30, 1'b1, 1'b1, 1'b0, -1);
        run_sched(1'b0, {$urandom, $urandom, $urandom, $urandom}, 30, 1'b1, 1'b1, 1'b0, -1);
    endtask

    initial begin : main
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_start_held_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter KR_TIMEOUT, default 64, max cycles COLLECT waits between kg_keyready pulses.
REQ-002 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a key schedule run; sampled in IDLE only.
REQ-005 SHALL have port encode  input  1  1 = encrypt order, 0 = decrypt order; latched with start.
REQ-006 SHALL have port key  input  128  cipher key, [127:96] = word 0; latched with start.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse after last round key accepted.
REQ-009 SHALL have port err  output  1  one-cycle pulse on key-generator timeout.
REQ-010 SHALL have port kg_cipherready  output  1  one-cycle load pulse to key generator.
REQ-011 SHALL have port kg_encode  output  1  latched encode, held stable while busy.
REQ-012 SHALL have port kg_key  output  128  latched key, driven to key generator ck0..ck3.
REQ-013 SHALL have port kg_keyready  input  1  key generator round-key-valid strobe.
REQ-014 SHALL have port kg_rkey  input  128  key generator out0..out3 concatenated.
REQ-015 SHALL have port rk_valid  output  1  round key presented to round datapath.
REQ-016 SHALL have port rk_ready  input  1  round datapath accepts round key.
REQ-017 SHALL have port rk_key  output  128  presented round key.
REQ-018 SHALL have port rk_index  output  4  index 0..10 of presented key.
REQ-019 SHALL have port rk_last  output  1  high with the final key of the run.

Function
REQ-020 SHALL implement states IDLE, LOAD, COLLECT, ISSUE.
REQ-021 IDLE: start=1 latches key/encode into buffer slot 0 and kg_key/kg_encode, -> LOAD next cycle.
REQ-022 LOAD: kg_cipherready=1 for exactly one cycle, clear key counter n=1 and timeout counter, -> COLLECT.
REQ-023 COLLECT: each kg_keyready=1 stores kg_rkey in slot n, n+1, timeout counter cleared; store of slot 10 -> ISSUE next cycle.
REQ-024 COLLECT: timeout counter reaching KR_TIMEOUT without kg_keyready -> err pulse, -> IDLE, no done.
REQ-025 kg_keyready outside COLLECT, or after slot 10 stored, SHALL be ignored.
REQ-026 ISSUE: encode=1 presents slots 0,1..10; encode=0 presents slots 10,9..0; rk_index = slot number.
REQ-027 rk_valid/rk_key/rk_index SHALL be stable while rk_valid=1 and rk_ready=0; transfer occurs on rk_valid&rk_ready.
REQ-028 Back-to-back transfers allowed: next key presented the cycle after a transfer, no bubble.
REQ-029 rk_last=1 only with slot 10 (encode) or slot 0 (decode).
REQ-030 Transfer with rk_last -> rk_valid=0 and done=1 the next cycle, state IDLE; busy=0 that cycle.
REQ-031 start while busy SHALL be ignored; latched key/encode unchanged.
REQ-032 rk_ready while rk_valid=0 SHALL have no effect.
REQ-033 Buffer: 11 x 128 bits, written only in IDLE (slot 0) and COLLECT.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, and busy, done, err, kg_cipherready, rk_valid, rk_last, rk_index, timeout and key counters to 0, from any state including mid-COLLECT or mid-ISSUE.
REQ-035 kg_key, kg_encode, rk_key, buffer SHALL reset to 0; first start after reset behaves identically to any other.

Verification
REQ-036 Encrypt: key 2b7e151628aed2a6abf7158809cf4f3c, encode=1, behavioral keygen model, rk_ready=1 -> 11 keys idx 0..10, idx 1 = a0fafe1788542cb123a339392a6c7605, idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last, then done pulse.
REQ-037 Decrypt: same key, encode=0 -> idx 10 first (d014f9a8...) through idx 0 (2b7e1516...) with rk_last, done pulse.
REQ-038 Backpressure: rk_ready toggled pseudo-randomly -> rk_key/rk_index stable while stalled, no key lost or duplicated, 11 transfers total.
REQ-039 Timeout: keygen model stops after 3 keyready pulses -> err pulse KR_TIMEOUT cycles after the 3rd, IDLE, rk_valid never asserted, done never asserted.
REQ-040 Reset mid-ISSUE after idx 4 transfer -> next cycle rk_valid=0, busy=0; new start runs full sequence from idx 0.
REQ-041 start held high during run and extra kg_keyready pulses in ISSUE -> single run, outputs unchanged.
